pipeline_hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage MIPS core. Generates the `freeze`/`flush` controls for the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and the EX-stage forwarding selects. It consumes the ID/EX latch outputs (`rs_out`, `rt_out`, resolved write destination, `RegWrite_out`, `dREN_out`, `dWEN_out`, `halt_out`). Internally it keeps its own MEM/WB destination scoreboard and a halt-drain FSM.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipeline_hazard_ctrl_if.sv | 55 +++++
 rtl/fwd_select.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the five-stage core hazard controller:
// forwarding selects, halt FSM states and scoreboard entries.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_t;

    typedef enum logic [1:0] {
        HC_RUN,
        HC_DRAIN,
        HC_HALTED
    } hc_state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] dest;
        logic       regwrite;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // $0 is hardwired, so it never produces a hit
    function automatic logic sb_hit(sb_entry_t e, logic [4:0] r);
        return e.v & e.regwrite & (e.dest == r) & (r != 5'd0);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-controller signals with controller
// and bench views.
interface pipeline_hazard_ctrl_if (
    input logic CLK
);
    logic       RST;
    logic       ihit;
    logic       dhit;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_wdest;
    logic       ex_regwrite;
    logic       ex_dren;
    logic       ex_dwen;
    logic       ex_halt;
    logic       ex_redirect;
    logic       ifid_freeze;
    logic       idex_freeze;
    logic       exmem_freeze;
    logic       memwb_freeze;
    logic       ifid_flush;
    logic       idex_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       halt;

    modport hc (
        input  CLK, RST, ihit, dhit,
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_rs, ex_rt, ex_wdest,
        input  ex_regwrite, ex_dren, ex_dwen,
        input  ex_halt, ex_redirect,
        output ifid_freeze, idex_freeze,
        output exmem_freeze, memwb_freeze,
        output ifid_flush, idex_flush,
        output fwd_a, fwd_b, halt
    );

    modport tb (
        input  CLK,
        output RST, ihit, dhit,
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_rs, ex_rt, ex_wdest,
        output ex_regwrite, ex_dren, ex_dwen,
        output ex_halt, ex_redirect,
        input  ifid_freeze, idex_freeze,
        input  exmem_freeze, memwb_freeze,
        input  ifid_flush, idex_flush,
        input  fwd_a, fwd_b, halt
    );
endinterface

// File: rtl/fwd_select.sv
// Per-operand EX forwarding select from MEM/WB scoreboard
// entries; MEM is the younger producer and wins.
module fwd_select
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] op_i,
    input  sb_entry_t  mem_i,
    input  sb_entry_t  wb_i,
    output fwd_t       sel_o
);
    always_comb begin
        sel_o = FWD_RF;
        if (sb_hit(mem_i, op_i)) begin
            sel_o = FWD_MEM;
        end else if (sb_hit(wb_i, op_i)) begin
            sel_o = FWD_WB;
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush sequencing, forwarding and halt drain for
// the five-stage MIPS pipeline latches.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_STAGES = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_wdest,
    input  logic       ex_regwrite,
    input  logic       ex_dren,
    input  logic       ex_dwen,
    input  logic       ex_halt,
    input  logic       ex_redirect,
    output logic       ifid_freeze,
    output logic       idex_freeze,
    output logic       exmem_freeze,
    output logic       memwb_freeze,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       halt
);
    localparam int CW =
        (DRAIN_STAGES < 2) ? 1 : $clog2(DRAIN_STAGES + 1);

    sb_entry_t mem_q, mem_d, wb_q, wb_d;
    sb_entry_t mem_e, wb_e;
    logic      mem_acc_q, mem_acc_d;
    logic      bub_q, bub_d;
    hc_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic      mem_wait, adv, lu;
    logic      halted, draining;
    fwd_t      fa, fb;

    assign halted   = state_q == HC_HALTED;
    assign draining = state_q == HC_DRAIN;
    assign mem_wait = mem_q.v & mem_acc_q & ~dhit;
    assign adv      = ihit & ~mem_wait & ~halted;
    assign halt     = halted;

    assign lu = ex_dren & ex_regwrite & (ex_wdest != 5'd0)
              & ((id_use_rs & (id_rs == ex_wdest))
              |  (id_use_rt & (id_rt == ex_wdest)));

    // Hide stale scoreboard contents while reset is held
    always_comb begin
        mem_e   = mem_q;
        wb_e    = wb_q;
        mem_e.v = mem_q.v & ~RST;
        wb_e.v  = wb_q.v & ~RST;
    end

    fwd_select u_fwd_a (
        .op_i  (ex_rs),
        .mem_i (mem_e),
        .wb_i  (wb_e),
        .sel_o (fa)
    );

    fwd_select u_fwd_b (
        .op_i  (ex_rt),
        .mem_i (mem_e),
        .wb_i  (wb_e),
        .sel_o (fb)
    );

    assign fwd_a = fa;
    assign fwd_b = fb;

    always_comb begin
        ifid_freeze  = 1'b0;
        idex_freeze  = 1'b0;
        exmem_freeze = 1'b0;
        memwb_freeze = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        priority case (1'b1)
            RST: begin
                ifid_freeze  = ~ihit;
                idex_freeze  = ~ihit;
                exmem_freeze = ~ihit;
                memwb_freeze = ~ihit;
            end
            halted, mem_wait, ~ihit: begin
                ifid_freeze  = 1'b1;
                idex_freeze  = 1'b1;
                exmem_freeze = 1'b1;
                memwb_freeze = 1'b1;
            end
            ex_redirect, draining: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            lu: begin
                ifid_freeze = 1'b1;
                idex_flush  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_d     = mem_q;
        mem_acc_d = mem_acc_q;
        wb_d      = wb_q;
        bub_d     = bub_q;
        if (adv) begin
            mem_d.v        = ~bub_q;
            mem_d.dest     = ex_wdest;
            mem_d.regwrite = ex_regwrite;
            mem_acc_d      = ex_dren | ex_dwen;
            wb_d           = mem_q;
            bub_d          = idex_flush;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            HC_RUN: begin
                if (ex_halt & adv & ~ex_redirect) begin
                    state_d = (DRAIN_STAGES == 0)
                            ? HC_HALTED : HC_DRAIN;
                    cnt_d   = CW'(DRAIN_STAGES);
                end
            end
            HC_DRAIN: begin
                if (adv) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_d = HC_HALTED;
                    end
                end
            end
            HC_HALTED: ;
            default: state_d = HC_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_q     <= SB_EMPTY;
            mem_acc_q <= 1'b0;
            wb_q      <= SB_EMPTY;
            bub_q     <= 1'b0;
            state_q   <= HC_RUN;
            cnt_q     <= '0;
        end else begin
            mem_q     <= mem_d;
            mem_acc_q <= mem_acc_d;
            wb_q      <= wb_d;
            bub_q     <= bub_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: per-cycle expected outputs queued
// at drive time and compared on the falling edge.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hif (.CLK(clk));

    pipeline_hazard_ctrl #(.DRAIN_STAGES(3)) dut (
        .CLK          (clk),
        .RST          (hif.RST),
        .ihit         (hif.ihit),
        .dhit         (hif.dhit),
        .id_rs        (hif.id_rs),
        .id_rt        (hif.id_rt),
        .id_use_rs    (hif.id_use_rs),
        .id_use_rt    (hif.id_use_rt),
        .ex_rs        (hif.ex_rs),
        .ex_rt        (hif.ex_rt),
        .ex_wdest     (hif.ex_wdest),
        .ex_regwrite  (hif.ex_regwrite),
        .ex_dren      (hif.ex_dren),
        .ex_dwen      (hif.ex_dwen),
        .ex_halt      (hif.ex_halt),
        .ex_redirect  (hif.ex_redirect),
        .ifid_freeze  (hif.ifid_freeze),
        .idex_freeze  (hif.idex_freeze),
        .exmem_freeze (hif.exmem_freeze),
        .memwb_freeze (hif.memwb_freeze),
        .ifid_flush   (hif.ifid_flush),
        .idex_flush   (hif.idex_flush),
        .fwd_a        (hif.fwd_a),
        .fwd_b        (hif.fwd_b),
        .halt         (hif.halt)
    );

    typedef struct packed {
        logic       rst, ihit, dhit;
        logic [4:0] id_rs, id_rt;
        logic       use_rs, use_rt;
        logic [4:0] ex_rs, ex_rt, ex_wd;
        logic       rw, dren, dwen, hlt, redir;
    } stim_t;

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } sb_t;

    sb_t   q[$];
    sb_t   cur;
    stim_t st;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.ihit = 1'b1;
        s.dhit = 1'b1;
        return s;
    endfunction

    // {freezes if/id/ex/mem, flushes if/id, fwd_a, fwd_b, halt}
    function automatic logic [10:0] e(
        input logic [3:0] fr, input logic [1:0] fl,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic h);
        return {fr, fl, fa, fb, h};
    endfunction

    task automatic apply(input stim_t s);
        hif.RST         = s.rst;
        hif.ihit        = s.ihit;
        hif.dhit        = s.dhit;
        hif.id_rs       = s.id_rs;
        hif.id_rt       = s.id_rt;
        hif.id_use_rs   = s.use_rs;
        hif.id_use_rt   = s.use_rt;
        hif.ex_rs       = s.ex_rs;
        hif.ex_rt       = s.ex_rt;
        hif.ex_wdest    = s.ex_wd;
        hif.ex_regwrite = s.rw;
        hif.ex_dren     = s.dren;
        hif.ex_dwen     = s.dwen;
        hif.ex_halt     = s.hlt;
        hif.ex_redirect = s.redir;
    endtask

    task automatic cyc(input string tag,
                       input logic [10:0] exp);
        sb_t it;
        @(posedge clk);
        #1;
        apply(st);
        it.tag = tag;
        it.exp = exp;
        q.push_back(it);
    endtask

    task automatic exi(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wd, input logic rw);
        st = idle();
        st.ex_rs = rs;
        st.ex_rt = rt;
        st.ex_wd = wd;
        st.rw    = rw;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            cur = q.pop_front();
            check(cur.tag,
                  {21'd0, hif.ifid_freeze, hif.idex_freeze,
                   hif.exmem_freeze, hif.memwb_freeze,
                   hif.ifid_flush, hif.idex_flush,
                   hif.fwd_a, hif.fwd_b, hif.halt},
                  {21'd0, cur.exp});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end in time");
        $fatal(1);
    end

    initial begin
        st = idle();
        st.rst  = 1'b1;
        st.ihit = 1'b0;
        apply(st);

        cyc("rst_ihit0", e(4'b1111, 2'b00, 2'b00, 2'b00, 1'b0));
        st.ihit = 1'b1;
        cyc("rst_ihit1", e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));

        exi(5'd1, 5'd2, 5'd3, 1'b1);
        cyc("add_ex",    e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        exi(5'd3, 5'd5, 5'd4, 1'b1);
        cyc("fwd_mem",   e(4'b0000, 2'b00, 2'b01, 2'b00, 1'b0));
        exi(5'd0, 5'd0, 5'd0, 1'b0);
        cyc("nop1",      e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        exi(5'd1, 5'd2, 5'd3, 1'b1);
        cyc("add_ex2",   e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        exi(5'd0, 5'd0, 5'd0, 1'b0);
        cyc("nop2",      e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        exi(5'd3, 5'd5, 5'd4, 1'b1);
        cyc("fwd_wb",    e(4'b0000, 2'b00, 2'b10, 2'b00, 1'b0));
        exi(5'd4, 5'd0, 5'd4, 1'b1);
        cyc("fwd_mem4",  e(4'b0000, 2'b00, 2'b01, 2'b00, 1'b0));
        exi(5'd4, 5'd4, 5'd0, 1'b0);
        cyc("fwd_prio",  e(4'b0000, 2'b00, 2'b01, 2'b01, 1'b0));
        exi(5'd0, 5'd4, 5'd0, 1'b0);
        cyc("fwd_rt_wb", e(4'b0000, 2'b00, 2'b00, 2'b10, 1'b0));

        exi(5'd9, 5'd8, 5'd8, 1'b1);
        st.dren = 1'b1;
        st.id_rt = 5'd8;
        st.use_rt = 1'b1;
        cyc("lu_stall",  e(4'b1000, 2'b01, 2'b00, 2'b00, 1'b0));
        exi(5'd0, 5'd0, 5'd0, 1'b0);
        st.id_rt = 5'd8;
        st.use_rt = 1'b1;
        cyc("lu_bubble", e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        exi(5'd7, 5'd8, 5'd10, 1'b1);
        cyc("lu_fwd_wb", e(4'b0000, 2'b00, 2'b00, 2'b10, 1'b0));

        exi(5'd9, 5'd8, 5'd8, 1'b1);
        st.dren = 1'b1;
        st.id_rt = 5'd8;
        st.use_rt = 1'b1;
        st.redir = 1'b1;
        cyc("redir_lu",  e(4'b0000, 2'b11, 2'b00, 2'b00, 1'b0));
        exi(5'd0, 5'd0, 5'd0, 1'b0);
        cyc("redir_bub", e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));

        exi(5'd0, 5'd0, 5'd7, 1'b1);
        cyc("add7",      e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        exi(5'd0, 5'd0, 5'd0, 1'b0);
        st.dwen = 1'b1;
        cyc("sw_ex",     e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        for (int i = 0; i < 4; i++) begin
            exi(5'd7, 5'd0, 5'd11, 1'b1);
            st.dhit = 1'b0;
            cyc("memwait", e(4'b1111, 2'b00, 2'b10, 2'b00, 1'b0));
        end
        exi(5'd7, 5'd0, 5'd11, 1'b1);
        cyc("memrel",    e(4'b0000, 2'b00, 2'b10, 2'b00, 1'b0));
        exi(5'd11, 5'd7, 5'd0, 1'b0);
        cyc("post_wait", e(4'b0000, 2'b00, 2'b01, 2'b00, 1'b0));

        exi(5'd11, 5'd0, 5'd0, 1'b0);
        st.ihit = 1'b0;
        cyc("ihit_low",  e(4'b1111, 2'b00, 2'b10, 2'b00, 1'b0));
        exi(5'd11, 5'd0, 5'd0, 1'b0);
        cyc("ihit_back", e(4'b0000, 2'b00, 2'b10, 2'b00, 1'b0));

        exi(5'd0, 5'd0, 5'd0, 1'b1);
        st.dren = 1'b1;
        st.use_rs = 1'b1;
        cyc("r0_nostall", e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        exi(5'd0, 5'd0, 5'd0, 1'b0);
        cyc("r0_nofwd",  e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));

        exi(5'd0, 5'd0, 5'd0, 1'b0);
        st.hlt = 1'b1;
        cyc("halt_ex",   e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        st = idle();
        cyc("drain1",    e(4'b0000, 2'b11, 2'b00, 2'b00, 1'b0));
        st.ihit = 1'b0;
        cyc("drain_stl", e(4'b1111, 2'b00, 2'b00, 2'b00, 1'b0));
        st = idle();
        cyc("drain2",    e(4'b0000, 2'b11, 2'b00, 2'b00, 1'b0));
        cyc("drain3",    e(4'b0000, 2'b11, 2'b00, 2'b00, 1'b0));
        cyc("halted",    e(4'b1111, 2'b00, 2'b00, 2'b00, 1'b1));
        cyc("halt_stk",  e(4'b1111, 2'b00, 2'b00, 2'b00, 1'b1));
        st.rst = 1'b1;
        cyc("rst_halt",  e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b1));
        st = idle();
        cyc("after_rst", e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));

        st.hlt = 1'b1;
        st.redir = 1'b1;
        cyc("halt_redir", e(4'b0000, 2'b11, 2'b00, 2'b00, 1'b0));
        st = idle();
        cyc("no_drain",  e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));

        st.hlt = 1'b1;
        cyc("halt_ex2",  e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        st = idle();
        cyc("drain_a",   e(4'b0000, 2'b11, 2'b00, 2'b00, 1'b0));
        st.rst = 1'b1;
        cyc("rst_drain", e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        st = idle();
        cyc("run_again", e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));
        cyc("run_again2", e(4'b0000, 2'b00, 2'b00, 2'b00, 1'b0));

        repeat (2) @(posedge clk);
        check("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
